compressor_unit: RTL and testbench
==================================

// Module: compressor_unit
// PURPOSE
//   Base-Delta-Immediate (BDI) compressor/decompressor for one 256-bit cache line per cycle.
//   Picks the smallest encoding that represents the line exactly, packs it LSB-first, then expands it back.
//   Sits between the L2 fill path and the compressed data array; the decompressed output is the read-back path.
// PARAMETERS
//   LINE_W  256  cache line width in bits (fixed; other values unsupported)
// PORTS
//   clock               in   1    single clock, rising edge
//   reset_n             in   1    asynchronous, active-low reset
//   UnCompressedCache   in   256  raw line, sampled every cycle
//   CompressedCache     out  256  packed line, LSB-aligned, unused upper bits zero
//   CompressedEncoding  out  4    encoding tag for CompressedCache
//   CompressedSize      out  9    payload size in bits (0..256)
//   DeCompressedCache   out  256  line rebuilt from CompressedCache/CompressedEncoding
// BEHAVIOUR
//   Encodings (tag, size in bits):
//     ZEROS 0 (0); REPEAT 1 (64); B8D1 2 (96); B4D1 3 (96); B8D2 4 (128);
//     B2D1 5 (144); B4D2 6 (160); B8D4 7 (192); UNCOMP 8 (256).
//   BkDn: split the line into k-byte elements; element 0 is bits [8k-1:0].
//     base = element 0; delta_i = element_i - base, modulo 2^(8k).
//     Fits iff delta_i, read as signed, is within the n-byte signed range for every i.
//   Selection priority: ZEROS (all bits 0), REPEAT (four identical 64-bit words),
//     then B8D1, B4D1, B8D2, B2D1, B4D2, B8D4, UNCOMP. The first legal encoding wins.
//   Packing: base in [8k-1:0]; delta_i (n bytes, truncated) in the following slots in element order, delta_0 included.
//     REPEAT packs the 64-bit word in [63:0]. UNCOMP passes the line through unchanged. ZEROS outputs all zero.
//   Decompress: element_i = base + sign_extend(delta_i), modulo 2^(8k). Must reproduce the input bit-exactly.
//   Latency:
//     Compress stage is registered: CompressedCache, Encoding and Size are valid 1 cycle after input sampling.
//     Decompress stage is registered from the compress registers: DeCompressedCache is valid 2 cycles after input.
//   Fully pipelined, one new line per cycle. No handshake and no stall.
//   Reset (async assert, sync release): all outputs 0; Encoding = ZEROS, Size = 0.
//     The reset state is therefore self-consistent: ZEROS decodes to 0.
//   Reset mid-stream flushes both stages. The first valid outputs follow 1 and 2 cycles after release.
//   Compression logic is combinational between input and compress registers. Input is not registered first.
// CONFIGURATION
//   COMPRESSOR_CHECK_EN defined:
//     Adds output RoundTripError (1 bit). The raw input is delayed 2 cycles.
//     RoundTripError is registered high when DeCompressedCache differs from that delayed input; reset value 0.
//     It must never assert.
//   COMPRESSOR_CHECK_EN undefined: the port and the delay line are absent. Nothing else changes.
// STRUCTURE
//   Package compressor_pkg:
//     enc_t enum (the 9 tags above);
//     ENC_SIZE lookup (tag -> bits);
//     LINE_W;
//     per-encoding base/delta byte-width constants.
//   Sub-module bdi_fit_check (params BASE_BYTES, DELTA_BYTES):
//     Input: line. Outputs: fits flag and packed payload.
//     Instantiated six times; the top level does priority select, registers and decompression.
// TESTING
//   1 Reset asserted mid-stream -> all outputs 0 immediately; Encoding 0, Size 0.
//   2 Line all zero -> 1 cycle later Encoding ZEROS, Size 0, CompressedCache 0.
//     2 cycles later DeCompressedCache is 0.
//   3 Four 64-bit words 0xDEADBEEF00000001 -> REPEAT, Size 64, CompressedCache[63:0]=0xDEADBEEF00000001.
//   4 64-bit words (element0 first) 0x10,0x20,0x30,0x40 -> B8D1, Size 96.
//     [63:0]=0x10, [95:64]=0x30201000.
//   5 64-bit words 0x0,0x1122,0x3344,0x5566 -> B8D2, Size 128.
//     [127:64]=0x5566_3344_1122_0000. Decompressed equals input at +2.
//   6 Alternating 0x0123456789ABCDEF/0xFEDCBA9876543210, then back-to-back vectors 3..5 on consecutive cycles
//     -> UNCOMP (Size 256, pass-through) followed by the expected tags in order.
//     Every DeCompressedCache equals its input 2 cycles earlier.

Source files
------------

// File: rtl/compressor_pkg.sv
// Shared types and constants for the BDI line compressor: encoding tags,
// payload sizes and the base/delta byte widths of each BkDn encoding.
package compressor_pkg;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned NUM_BDI = 6;

    typedef enum logic [3:0] {
        ENC_ZEROS  = 4'd0,
        ENC_REPEAT = 4'd1,
        ENC_B8D1   = 4'd2,
        ENC_B4D1   = 4'd3,
        ENC_B8D2   = 4'd4,
        ENC_B2D1   = 4'd5,
        ENC_B4D2   = 4'd6,
        ENC_B8D4   = 4'd7,
        ENC_UNCOMP = 4'd8
    } enc_t;

    localparam int unsigned B8D1_BASE_BYTES = 8, B8D1_DELTA_BYTES = 1;
    localparam int unsigned B4D1_BASE_BYTES = 4, B4D1_DELTA_BYTES = 1;
    localparam int unsigned B8D2_BASE_BYTES = 8, B8D2_DELTA_BYTES = 2;
    localparam int unsigned B2D1_BASE_BYTES = 2, B2D1_DELTA_BYTES = 1;
    localparam int unsigned B4D2_BASE_BYTES = 4, B4D2_DELTA_BYTES = 2;
    localparam int unsigned B8D4_BASE_BYTES = 8, B8D4_DELTA_BYTES = 4;

    function automatic logic [8:0] enc_size(input enc_t e);
        case (e)
            ENC_ZEROS:  return 9'd0;
            ENC_REPEAT: return 9'd64;
            ENC_B8D1:   return 9'd96;
            ENC_B4D1:   return 9'd96;
            ENC_B8D2:   return 9'd128;
            ENC_B2D1:   return 9'd144;
            ENC_B4D2:   return 9'd160;
            ENC_B8D4:   return 9'd192;
            default:    return 9'd256;
        endcase
    endfunction

    function automatic int unsigned bdi_base_bytes(input enc_t e);
        case (e)
            ENC_B8D1: return B8D1_BASE_BYTES;
            ENC_B4D1: return B4D1_BASE_BYTES;
            ENC_B8D2: return B8D2_BASE_BYTES;
            ENC_B2D1: return B2D1_BASE_BYTES;
            ENC_B4D2: return B4D2_BASE_BYTES;
            default:  return B8D4_BASE_BYTES;
        endcase
    endfunction

    function automatic int unsigned bdi_delta_bytes(input enc_t e);
        case (e)
            ENC_B8D1: return B8D1_DELTA_BYTES;
            ENC_B4D1: return B4D1_DELTA_BYTES;
            ENC_B8D2: return B8D2_DELTA_BYTES;
            ENC_B2D1: return B2D1_DELTA_BYTES;
            ENC_B4D2: return B4D2_DELTA_BYTES;
            default:  return B8D4_DELTA_BYTES;
        endcase
    endfunction

endpackage

// File: rtl/bdi_fit_check.sv
// One BkDn candidate: tests whether every element's delta from element 0
// fits the signed delta width, and packs base plus truncated deltas LSB-first.
module bdi_fit_check
    import compressor_pkg::*;
#(
    parameter int unsigned BASE_BYTES  = 8,
    parameter int unsigned DELTA_BYTES = 1
) (
    input  logic [LINE_W-1:0] i_line,
    output logic              o_fits,
    output logic [LINE_W-1:0] o_payload
);

    localparam int unsigned K  = BASE_BYTES * 8;
    localparam int unsigned N  = DELTA_BYTES * 8;
    localparam int unsigned NE = LINE_W / K;

    logic [K-1:0] w_diff;

    // A delta fits when all bits from N-1 upward equal the sign bit.
    always_comb begin
        o_fits    = 1'b1;
        o_payload = '0;
        w_diff    = '0;
        o_payload[K-1:0] = i_line[K-1:0];
        for (int unsigned i = 0; i < NE; i++) begin
            w_diff = i_line[i*K +: K] - i_line[K-1:0];
            if (!((&w_diff[K-1:N-1]) || !(|w_diff[K-1:N-1])))
                o_fits = 1'b0;
            o_payload[K + i*N +: N] = w_diff[N-1:0];
        end
    end

endmodule

// File: rtl/compressor_unit.sv
// BDI compressor/decompressor: one 256-bit line per cycle, compress stage at +1,
// decompress stage at +2. Define COMPRESSOR_CHECK_EN to add the RoundTripError monitor.
module compressor_unit
    import compressor_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [LINE_W-1:0] UnCompressedCache,
    output logic [LINE_W-1:0] CompressedCache,
    output logic [3:0]        CompressedEncoding,
    output logic [8:0]        CompressedSize,
    output logic [LINE_W-1:0] DeCompressedCache
`ifdef COMPRESSOR_CHECK_EN
    ,
    output logic              RoundTripError
`endif
);

    logic [NUM_BDI-1:0] w_fits;
    logic [LINE_W-1:0]  w_pay [NUM_BDI];
    logic [LINE_W-1:0]  w_exp [NUM_BDI];
    logic               w_is_zero;
    logic               w_is_repeat;
    enc_t               w_enc;
    logic [LINE_W-1:0]  w_payload;
    logic [LINE_W-1:0]  w_decomp;

    logic [LINE_W-1:0]  r_comp;
    enc_t               r_enc;
    logic [8:0]         r_size;
    logic [LINE_W-1:0]  r_decomp;

    // Generate index g maps to tag g+2, so tag order is also priority order.
    for (genvar g = 0; g < NUM_BDI; g++) begin : g_bdi
        localparam enc_t        ENC = enc_t'(4'(g + 2));
        localparam int unsigned KB  = bdi_base_bytes(ENC);
        localparam int unsigned DB  = bdi_delta_bytes(ENC);
        localparam int unsigned K   = KB * 8;
        localparam int unsigned N   = DB * 8;
        localparam int unsigned NE  = LINE_W / K;

        logic              w_fit_g;
        logic [LINE_W-1:0] w_pay_g;
        logic [LINE_W-1:0] w_exp_g;
        logic [N-1:0]      w_delta;

        bdi_fit_check #(
            .BASE_BYTES  (KB),
            .DELTA_BYTES (DB)
        ) u_fit (
            .i_line    (UnCompressedCache),
            .o_fits    (w_fit_g),
            .o_payload (w_pay_g)
        );

        always_comb begin
            w_exp_g = '0;
            w_delta = '0;
            for (int unsigned i = 0; i < NE; i++) begin
                w_delta = r_comp[K + i*N +: N];
                w_exp_g[i*K +: K] = r_comp[K-1:0] + {{(K-N){w_delta[N-1]}}, w_delta};
            end
        end

        assign w_fits[g] = w_fit_g;
        assign w_pay[g]  = w_pay_g;
        assign w_exp[g]  = w_exp_g;
    end

    assign w_is_zero   = ~|UnCompressedCache;
    assign w_is_repeat = (UnCompressedCache[63:0] == UnCompressedCache[127:64])
                      && (UnCompressedCache[63:0] == UnCompressedCache[191:128])
                      && (UnCompressedCache[63:0] == UnCompressedCache[255:192]);

    // Walk candidates from lowest to highest priority so the last hit wins.
    always_comb begin
        w_enc     = ENC_UNCOMP;
        w_payload = UnCompressedCache;
        for (int unsigned j = 0; j < NUM_BDI; j++) begin
            if (w_fits[NUM_BDI-1-j]) begin
                w_enc     = enc_t'(4'(NUM_BDI + 1 - j));
                w_payload = w_pay[NUM_BDI-1-j];
            end
        end
        if (w_is_repeat) begin
            w_enc     = ENC_REPEAT;
            w_payload = {{(LINE_W-64){1'b0}}, UnCompressedCache[63:0]};
        end
        if (w_is_zero) begin
            w_enc     = ENC_ZEROS;
            w_payload = '0;
        end
    end

    always_comb begin
        case (r_enc)
            ENC_ZEROS:  w_decomp = '0;
            ENC_REPEAT: w_decomp = {4{r_comp[63:0]}};
            ENC_B8D1:   w_decomp = w_exp[0];
            ENC_B4D1:   w_decomp = w_exp[1];
            ENC_B8D2:   w_decomp = w_exp[2];
            ENC_B2D1:   w_decomp = w_exp[3];
            ENC_B4D2:   w_decomp = w_exp[4];
            ENC_B8D4:   w_decomp = w_exp[5];
            default:    w_decomp = r_comp;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_comp   <= '0;
            r_enc    <= ENC_ZEROS;
            r_size   <= '0;
            r_decomp <= '0;
        end else begin
            r_comp   <= w_payload;
            r_enc    <= w_enc;
            r_size   <= enc_size(w_enc);
            r_decomp <= w_decomp;
        end
    end

    assign CompressedCache    = r_comp;
    assign CompressedEncoding = r_enc;
    assign CompressedSize     = r_size;
    assign DeCompressedCache  = r_decomp;

`ifdef COMPRESSOR_CHECK_EN
    logic [LINE_W-1:0] r_in_d1;
    logic [LINE_W-1:0] r_in_d2;
    logic              r_rt_err;

    // r_in_d2 lines up with r_decomp; the mismatch flag lands one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_d1  <= '0;
            r_in_d2  <= '0;
            r_rt_err <= 1'b0;
        end else begin
            r_in_d1  <= UnCompressedCache;
            r_in_d2  <= r_in_d1;
            r_rt_err <= (r_decomp != r_in_d2);
        end
    end

    assign RoundTripError = r_rt_err;
`endif

endmodule

// File: tb/tb_compressor_unit.sv
// Directed, table-driven bench for compressor_unit with hand-computed packed lines.
module tb_compressor_unit;

    typedef struct {
        string        name;
        logic [255:0] line;
        logic [3:0]   enc;
        logic [8:0]   size;
        logic [255:0] comp;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] din = '0;
    logic [255:0] comp_o;
    logic [3:0]   enc_o;
    logic [8:0]   size_o;
    logic [255:0] decomp_o;
    int           n_tests = 0;
    int           n_fail  = 0;
    vec_t         vecs [11];
    vec_t         seq  [4];

`ifdef COMPRESSOR_CHECK_EN
    logic rt_err;
    logic rt_seen = 1'b0;
`endif

    compressor_unit dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .UnCompressedCache  (din),
        .CompressedCache    (comp_o),
        .CompressedEncoding (enc_o),
        .CompressedSize     (size_o),
        .DeCompressedCache  (decomp_o)
`ifdef COMPRESSOR_CHECK_EN
        ,
        .RoundTripError     (rt_err)
`endif
    );

    always #5 clock = ~clock;

`ifdef COMPRESSOR_CHECK_EN
    always @(negedge clock) if (rt_err === 1'b1) rt_seen = 1'b1;
`endif

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] w4(input logic [63:0] e0, input logic [63:0] e1,
                                        input logic [63:0] e2, input logic [63:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check_comp(input vec_t v);
        check({v.name, " comp"}, comp_o, v.comp);
        check({v.name, " enc"},  256'(enc_o),  256'(v.enc));
        check({v.name, " size"}, 256'(size_o), 256'(v.size));
    endtask

    initial begin
        vecs[0]  = '{"zeros",  '0, 4'd0, 9'd0, '0};
        vecs[1]  = '{"repeat", w4(64'hDEADBEEF00000001, 64'hDEADBEEF00000001,
                                  64'hDEADBEEF00000001, 64'hDEADBEEF00000001),
                     4'd1, 9'd64, 256'hDEADBEEF00000001};
        vecs[2]  = '{"b8d1", w4(64'h10, 64'h20, 64'h30, 64'h40), 4'd2, 9'd96,
                     {160'd0, 32'h30201000, 64'h10}};
        vecs[3]  = '{"b8d1_edge", w4(64'h100, 64'hFF, 64'h17F, 64'h80), 4'd2, 9'd96,
                     {160'd0, 32'h807FFF00, 64'h100}};
        vecs[4]  = '{"b8d2", w4(64'h0, 64'h1122, 64'h3344, 64'h5566), 4'd4, 9'd128,
                     {128'd0, 64'h5566334411220000, 64'h0}};
        vecs[5]  = '{"b8d2_edge", w4(64'h100, 64'hFF, 64'h180, 64'h80), 4'd4, 9'd128,
                     {128'd0, 64'hFF800080FFFF0000, 64'h100}};
        vecs[6]  = '{"b4d1",
                     256'h10000007_10000006_10000005_10000004_10000003_10000002_10000001_10000000,
                     4'd3, 9'd96, {160'd0, 64'h0706050403020100, 32'h10000000}};
        vecs[7]  = '{"b2d1",
                     256'h1243_1242_1241_1240_123F_123E_123D_123C_123B_123A_1239_1238_1237_1236_1235_1234,
                     4'd5, 9'd144, {112'd0, 128'h0F0E0D0C0B0A09080706050403020100, 16'h1234}};
        vecs[8]  = '{"b4d2",
                     256'h40000700_40000600_40000500_40000400_40000300_40000200_40000100_40000000,
                     4'd6, 9'd160, {96'd0, 128'h07000600050004000300020001000000, 32'h40000000}};
        vecs[9]  = '{"b8d4", w4(64'h0, 64'h123456, 64'h2468AC, 64'h369D02), 4'd7, 9'd192,
                     {64'd0, 128'h00369D02_002468AC_00123456_00000000, 64'h0}};
        vecs[10] = '{"uncomp", w4(64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                  64'h0123456789ABCDEF, 64'hFEDCBA9876543210),
                     4'd8, 9'd256,
                     w4(64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                        64'h0123456789ABCDEF, 64'hFEDCBA9876543210)};
        seq[0] = vecs[10];
        seq[1] = vecs[1];
        seq[2] = vecs[2];
        seq[3] = vecs[4];

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst comp",   comp_o,          '0);
        check("rst enc",    256'(enc_o),     '0);
        check("rst size",   256'(size_o),    '0);
        check("rst decomp", decomp_o,        '0);
        @(negedge clock);
        reset_n = 1'b1;

        // Each vector held two cycles: compress result at +1, round trip at +2
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            din = vecs[i].line;
            @(posedge clock); #1;
            check_comp(vecs[i]);
            @(posedge clock); #1;
            check({vecs[i].name, " decomp"}, decomp_o, vecs[i].line);
        end

        // Back-to-back lines, one per cycle
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            din = (c < 4) ? seq[c].line : '0;
            @(posedge clock); #1;
            if (c < 4) check_comp(seq[c]);
            if (c >= 1) check({"b2b ", seq[c-1].name, " decomp"}, decomp_o, seq[c-1].line);
        end

        // Reset mid-stream with a full pipeline
        @(negedge clock);
        din = vecs[10].line;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst comp",   comp_o,      '0);
        check("midrst enc",    256'(enc_o), '0);
        check("midrst size",   256'(size_o), '0);
        check("midrst decomp", decomp_o,    '0);
        din = vecs[2].line;
        @(posedge clock); #1;
        check("held rst comp", comp_o, '0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_comp(vecs[2]);
        check("post rst decomp +1", decomp_o, '0);
        @(posedge clock); #1;
        check("post rst decomp +2", decomp_o, vecs[2].line);

`ifdef COMPRESSOR_CHECK_EN
        repeat (2) @(posedge clock); #1;
        check("roundtrip error", 256'(rt_seen), '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
